// File: rtl/cdb_arbiter.sv
// Writeback arbiter: per-FU result FIFOs feeding a single registered CDB with
// round-robin selection. Define CDB_FLUSH_EN to add a synchronous flush input.
module cdb_arbiter #(
    parameter int NUM_FU = 3,
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef CDB_FLUSH_EN
    input  logic                     flush,
`endif
    input  logic [NUM_FU-1:0]        fu_valid,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic [NUM_FU*TAG_W-1:0]  fu_rd,
    input  logic [NUM_FU*TAG_W-1:0]  fu_rob_idx,
    input  logic [NUM_FU*DATA_W-1:0] fu_value,
    input  logic [NUM_FU-1:0]        fu_regwrite,
    output logic                     cdb_valid,
    input  logic                     cdb_ready,
    output logic [TAG_W-1:0]         cdb_rd,
    output logic [TAG_W-1:0]         cdb_rob_idx,
    output logic [DATA_W-1:0]        cdb_value,
    output logic                     cdb_regwrite
);
    typedef struct packed {
        logic [TAG_W-1:0]  rd;
        logic [TAG_W-1:0]  rob_idx;
        logic [DATA_W-1:0] value;
        logic              regwrite;
    } cdb_ent_t;

    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              FW       = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam logic [PW:0]     CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [FW-1:0]   RR_INIT  = FW'(NUM_FU-1);

    logic flush_w;
`ifdef CDB_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    logic [NUM_FU-1:0]    nonempty;
    logic [NUM_FU-1:0]    pop;
    cdb_ent_t [NUM_FU-1:0] head;
    logic                 found;
    logic [FW-1:0]        winner;
    logic                 out_free;
    logic                 grant;

    cdb_ent_t      cdb_q, cdb_d;
    logic          cdb_valid_q, cdb_valid_d;
    logic [FW-1:0] rr_ptr_q, rr_ptr_d;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
        cdb_ent_t [DEPTH-1:0] mem_q, mem_d;
        logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
        logic [PW:0]          cnt_q, cnt_d;
        logic                 push;
        cdb_ent_t             in_ent;

        assign in_ent      = {fu_rd[i*TAG_W +: TAG_W], fu_rob_idx[i*TAG_W +: TAG_W],
                              fu_value[i*DATA_W +: DATA_W], fu_regwrite[i]};
        // Ready looks only at the registered count: a same-cycle pop never frees a slot.
        assign fu_ready[i] = (cnt_q != CNT_FULL);
        assign push        = fu_valid[i] && fu_ready[i] && !flush_w;
        assign nonempty[i] = (cnt_q != '0);
        assign head[i]     = mem_q[rptr_q];
        assign pop[i]      = grant && (winner == FW'(i));

        always_comb begin
            mem_d  = mem_q;
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            cnt_d  = cnt_q;
            if (flush_w) begin
                wptr_d = '0;
                rptr_d = '0;
                cnt_d  = '0;
            end else begin
                if (push) begin
                    mem_d[wptr_q] = in_ent;
                    wptr_d        = wptr_q + PW'(1);
                end
                if (pop[i]) rptr_d = rptr_q + PW'(1);
                if (push && !pop[i])      cnt_d = cnt_q + (PW+1)'(1);
                else if (!push && pop[i]) cnt_d = cnt_q - (PW+1)'(1);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                cnt_q  <= cnt_d;
            end
        end

        // Storage needs no reset: an entry is only read once the count says it was written.
        always_ff @(posedge clk) begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        logic [FW-1:0] j;
        found  = 1'b0;
        winner = rr_ptr_q;
        j      = '0;
        for (int k = 1; k <= NUM_FU; k++) begin
            j = FW'((int'(rr_ptr_q) + k) % NUM_FU);
            if (!found && nonempty[j]) begin
                found  = 1'b1;
                winner = j;
            end
        end
    end

    assign out_free = !cdb_valid_q || cdb_ready;
    assign grant    = out_free && found && !flush_w;

    always_comb begin
        cdb_valid_d = cdb_valid_q;
        cdb_d       = cdb_q;
        rr_ptr_d    = rr_ptr_q;
        if (flush_w) begin
            cdb_valid_d = 1'b0;
            rr_ptr_d    = RR_INIT;
        end else if (out_free) begin
            cdb_valid_d = found;
            if (found) begin
                cdb_d    = head[winner];
                rr_ptr_d = winner;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdb_valid_q <= 1'b0;
            cdb_q       <= '0;
            rr_ptr_q    <= RR_INIT;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_q       <= cdb_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign cdb_valid    = cdb_valid_q;
    assign cdb_rd       = cdb_q.rd;
    assign cdb_rob_idx  = cdb_q.rob_idx;
    assign cdb_value    = cdb_q.value;
    assign cdb_regwrite = cdb_q.regwrite;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter: queue-based reference model predicts each
// broadcast; a negedge monitor compares the bus against the expected queue.
module tb_cdb_arbiter;
    localparam int NUM_FU = 3;
    localparam int DEPTH  = 2;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [TAG_W-1:0]  rd;
        logic [TAG_W-1:0]  rob;
        logic [DATA_W-1:0] val;
        logic              rw;
    } ent_t;

    logic                     clk = 1'b0;
    logic                     rst;
`ifdef CDB_FLUSH_EN
    logic                     flush;
`endif
    logic [NUM_FU-1:0]        fu_valid;
    logic [NUM_FU-1:0]        fu_ready;
    logic [NUM_FU*TAG_W-1:0]  fu_rd;
    logic [NUM_FU*TAG_W-1:0]  fu_rob_idx;
    logic [NUM_FU*DATA_W-1:0] fu_value;
    logic [NUM_FU-1:0]        fu_regwrite;
    logic                     cdb_valid;
    logic                     cdb_ready;
    logic [TAG_W-1:0]         cdb_rd;
    logic [TAG_W-1:0]         cdb_rob_idx;
    logic [DATA_W-1:0]        cdb_value;
    logic                     cdb_regwrite;

    cdb_arbiter #(.NUM_FU(NUM_FU), .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(rst),
`ifdef CDB_FLUSH_EN
        .flush(flush),
`endif
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_rd(fu_rd), .fu_rob_idx(fu_rob_idx),
        .fu_value(fu_value), .fu_regwrite(fu_regwrite), .cdb_valid(cdb_valid),
        .cdb_ready(cdb_ready), .cdb_rd(cdb_rd), .cdb_rob_idx(cdb_rob_idx),
        .cdb_value(cdb_value), .cdb_regwrite(cdb_regwrite)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: per-FU queues of depth DEPTH, one output slot, round-robin pointer.
    ent_t mbuf[NUM_FU][DEPTH];
    int   mcnt[NUM_FU];
    bit   m_valid;
    int   m_rr;
    ent_t exp_q[$];

    always @(posedge clk or posedge rst) begin
        bit                fl;
        logic [NUM_FU-1:0] rdy;
        bit                fnd;
        int                w;
        fl = 1'b0;
`ifdef CDB_FLUSH_EN
        fl = flush;
`endif
        if (rst || fl) begin
            for (int i = 0; i < NUM_FU; i++) mcnt[i] = 0;
            m_valid = 1'b0;
            m_rr    = NUM_FU - 1;
            exp_q.delete();
        end else begin
            for (int i = 0; i < NUM_FU; i++) rdy[i] = (mcnt[i] != DEPTH);
            if (!m_valid || cdb_ready) begin
                fnd = 1'b0;
                w   = 0;
                for (int k = 1; k <= NUM_FU; k++) begin
                    int j;
                    j = (m_rr + k) % NUM_FU;
                    if (!fnd && mcnt[j] > 0) begin
                        fnd = 1'b1;
                        w   = j;
                    end
                end
                if (fnd) begin
                    exp_q.push_back(mbuf[w][0]);
                    for (int d = 0; d < DEPTH - 1; d++) mbuf[w][d] = mbuf[w][d+1];
                    mcnt[w]--;
                    m_valid = 1'b1;
                    m_rr    = w;
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && rdy[i]) begin
                    mbuf[i][mcnt[i]] = {fu_rd[i*TAG_W +: TAG_W], fu_rob_idx[i*TAG_W +: TAG_W],
                                        fu_value[i*DATA_W +: DATA_W], fu_regwrite[i]};
                    mcnt[i]++;
                end
            end
        end
    end

    // Monitor: compares bus and fu_ready against the model, consumes on handshake.
    always @(negedge clk) begin
        logic [NUM_FU-1:0] er;
        if (!rst) begin
            for (int i = 0; i < NUM_FU; i++) er[i] = (mcnt[i] != DEPTH);
            chk("fu_ready", fu_ready, er);
            chk("cdb_valid", cdb_valid, m_valid);
            if (cdb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("cdb_unexpected", 1, 0);
                end else begin
                    chk("cdb_entry", {cdb_rd, cdb_rob_idx, cdb_value, cdb_regwrite}, exp_q[0]);
                    if (cdb_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fu(input int i, input bit v, input logic [TAG_W-1:0] rd,
                            input logic [TAG_W-1:0] rob, input logic [DATA_W-1:0] val,
                            input bit rw);
        fu_valid[i]                  = v;
        fu_rd[i*TAG_W +: TAG_W]      = rd;
        fu_rob_idx[i*TAG_W +: TAG_W] = rob;
        fu_value[i*DATA_W +: DATA_W] = val;
        fu_regwrite[i]               = rw;
    endtask

    task automatic drain(input int n);
        fu_valid  = '0;
        cdb_ready = 1'b1;
        repeat (n) cyc();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int g;
        int sent;
        bit acc;
        rst = 1'b1;
`ifdef CDB_FLUSH_EN
        flush = 1'b0;
`endif
        fu_valid = '0; fu_rd = '0; fu_rob_idx = '0; fu_value = '0; fu_regwrite = '0;
        cdb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int c = 0; c < 10; c++) begin
            chk("idle_ready", fu_ready, 3'b111);
            chk("idle_valid", cdb_valid, 0);
            chk("idle_fields", {cdb_rd, cdb_rob_idx, cdb_value, cdb_regwrite}, 0);
            cyc();
        end

        // Every FU pushes every cycle: grants rotate 0,1,2 starting from FU0.
        g = 0;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < NUM_FU; i++)
                drive_fu(i, 1'b1, 6'($urandom), 6'($urandom), {8'(i), 24'(c)}, 1'($urandom));
            cyc();
            if (cdb_valid) begin
                chk("rr_grant", cdb_value[31:24], g % NUM_FU);
                g++;
            end
        end
        drain(8);

        drive_fu(1, 1'b1, 6'd12, 6'd5, 32'hDEADBEEF, 1'b1);
        cyc();
        fu_valid = '0;
        chk("single_lat", cdb_valid, 0);
        cyc();
        chk("single_valid", cdb_valid, 1);
        chk("single_fields", {cdb_rd, cdb_rob_idx, cdb_value, cdb_regwrite},
            {6'd12, 6'd5, 32'hDEADBEEF, 1'b1});
        cyc();
        chk("single_done", cdb_valid, 0);
        drain(3);

        // Backpressure on FU0: one result on the bus, two buffered, next push stalls.
        cdb_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            drive_fu(0, 1'b1, 6'(sent), 6'(sent + 1), 32'hB000_0000 + sent, 1'b1);
            acc = fu_ready[0];
            cyc();
            if (acc) sent++;
        end
        chk("bp_sent", sent, 3);
        chk("bp_full", fu_ready[0], 0);
        chk("bp_hold", cdb_value, 32'hB000_0000);
        fu_valid  = '0;
        cdb_ready = 1'b1;
        cyc();
        chk("bp_drain1", {cdb_valid, cdb_value}, {1'b1, 32'hB000_0001});
        cyc();
        chk("bp_drain2", {cdb_valid, cdb_value}, {1'b1, 32'hB000_0002});
        cyc();
        chk("bp_end", cdb_valid, 0);

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_FU; i++)
                drive_fu(i, 1'($urandom), 6'($urandom), 6'($urandom), $urandom, 1'($urandom));
            cdb_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        drain(10);

        // Asynchronous reset between edges with results buffered and on the bus.
        cdb_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < NUM_FU; i++)
                drive_fu(i, 1'b1, 6'($urandom), 6'($urandom), $urandom, 1'b1);
            cyc();
        end
        fu_valid = '0;
        chk("pre_rst_valid", cdb_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", cdb_valid, 0);
        chk("rst_async_ready", fu_ready, 3'b111);
        cyc();
        rst = 1'b0;
        cdb_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cyc();
            chk("no_stale", cdb_valid, 0);
        end

`ifdef CDB_FLUSH_EN
        cdb_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < NUM_FU; i++)
                drive_fu(i, 1'b1, 6'($urandom), 6'($urandom), {8'(i), 24'(c)}, 1'b1);
            cyc();
        end
        flush = 1'b1;
        cyc();
        flush    = 1'b0;
        fu_valid = '0;
        chk("flush_valid", cdb_valid, 0);
        chk("flush_ready", fu_ready, 3'b111);
        cdb_ready = 1'b1;
        for (int i = 0; i < NUM_FU; i++)
            drive_fu(i, 1'b1, 6'($urandom), 6'($urandom), {8'(i), 24'hF}, 1'b1);
        cyc();
        fu_valid = '0;
        cyc();
        chk("flush_rr_fu0", {cdb_valid, cdb_value[31:24]}, {1'b1, 8'd0});
        drain(6);
`endif

        drain(4);
        chk("final_idle", cdb_valid, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
